imm_rot_encoder: RTL
====================

IMM_ROT_ENCODER -- requirements
Module: imm_rot_encoder

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning), clock and reset first; one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  single clock, all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request (high only in IDLE).
REQ-006 value  input  `REGISTER_LEN (32)  constant to encode.
REQ-007 is_mem_command  input  1  1 = 12-bit signed memory offset mode; 0 = rotated-immediate mode.
REQ-008 out_valid  output  1  result present; held until accepted.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 shift_operand  output  12  encoded operand: {rot[3:0], imm8} in immediate mode, value[11:0] in memory mode.
REQ-011 fail  output  1  value is not encodable in the selected mode.
REQ-012 inverted  output  1  encoding is of ~value (MVN/BIC form); only with IMM_ENC_NEG_EN.

Function
REQ-013 States SHALL be IDLE, SEARCH, SEARCH_NEG, DONE; handshake fires on in_valid && in_ready; value and is_mem_command are captured at that edge (edge 0).
REQ-014 Immediate mode: in the cycle after edge k, candidate = captured operand rotated left by 2*k; a hit is candidate[31:8] == 0, with imm8 = candidate[7:0] and rot = k.
REQ-015 Rotations SHALL be tested in order 0..15; the smallest hitting rot wins.
REQ-016 On a hit tested after edge k, the state SHALL move to DONE at edge k+1 with out_valid = 1, fail = 0, and shift_operand = {k[3:0], imm8}.
REQ-017 Applying the decode ROR({24'b0, imm8}, 2*rot) to a successful result SHALL reproduce the captured operand exactly.
REQ-018 If no rot in 0..15 hits and IMM_ENC_NEG_EN is absent, the state SHALL move to DONE at edge 16 with fail = 1 and shift_operand = 0.
REQ-019 Memory mode: the state SHALL move to DONE at edge 1; the result is encodable iff value[31:11] is all-equal (sign-extends from bit 11).
REQ-020 In memory mode, encodable gives shift_operand = value[11:0], fail = 0; otherwise fail = 1, shift_operand = 0.
REQ-021 DONE holds all outputs stable until out_valid && out_ready, then returns to IDLE at that edge; in_ready = 1 in IDLE only.
REQ-022 in_valid outside IDLE SHALL be ignored, with no queuing.
REQ-023 The rotation counter SHALL be 4 bits and SHALL NOT wrap silently; reaching 15 without a hit terminates the pass.
REQ-024 inverted SHALL be 0 whenever fail = 1 or is_mem_command = 1.

Reset
REQ-025 rst SHALL force IDLE, out_valid = 0, fail = 0, inverted = 0, shift_operand = 0, rotation counter = 0 at the next edge, and SHALL abort any search or held result.
REQ-026 in_ready SHALL be 1 on the first edge after rst deasserts.

Configuration
REQ-027 Macro IMM_ENC_NEG_EN: when defined, an unsuccessful immediate pass SHALL run a second 16-rotation pass (SEARCH_NEG) on ~value.
REQ-028 With IMM_ENC_NEG_EN, a second-pass hit at rot k SHALL give DONE at edge 17+k with inverted = 1; a second-pass miss SHALL give fail = 1 at edge 32.
REQ-029 Without IMM_ENC_NEG_EN, SEARCH_NEG SHALL be absent and inverted SHALL be tied to 0.

Structure
REQ-030 The shared defines SHALL hold `REGISTER_LEN, the FSM state encodings, and ROT_STEPS = 16.
REQ-031 One combinational sub-module, rotl_even, SHALL compute the 32-bit rotate-left by 2*rot.

Verification
REQ-032 value = 0x000000FF, immediate mode -> out_valid at edge 1, shift_operand = 0x0FF, fail = 0.
REQ-033 value = 0xFF000000 -> out_valid at edge 5, shift_operand = 0x4FF.
REQ-034 value = 0x00000102 -> fail = 1 at edge 16, or at edge 32 with IMM_ENC_NEG_EN.
REQ-035 IMM_ENC_NEG_EN, value = 0xFFFFFF00 -> out_valid at edge 17, shift_operand = 0x0FF, inverted = 1.
REQ-036 Memory mode, value = 0xFFFFF800 -> shift_operand = 0x800 at edge 1; value = 0x00000800 -> fail = 1.
REQ-037 rst pulsed at edge 3 of a search, then out_ready held low for 4 cycles -> IDLE, out_valid = 0 after the reset edge; a held result stays stable until out_ready.

Source files
------------

// File: rtl/imm_rot_encoder_pkg.sv
// Shared definitions for the rotated-immediate / memory-offset encoder.
// Holds the register width, rotation step count and FSM state encodings.
// SEARCH_NEG only exists when IMM_ENC_NEG_EN is defined.
`ifndef REGISTER_LEN
`define REGISTER_LEN 32
`endif

package imm_rot_encoder_pkg;

    localparam int REG_LEN   = `REGISTER_LEN;
    localparam int ROT_STEPS = 16;
    localparam int ROT_W     = 4;
    localparam int OPND_W    = 12;

    // Last rotation index tested in a pass; reaching it without a hit ends the pass.
    localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT_STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SEARCH     = 2'd1,
`ifdef IMM_ENC_NEG_EN
        ST_SEARCH_NEG = 2'd2,
`endif
        ST_DONE       = 2'd3
    } state_e;

    // A memory offset fits when bits [REG_LEN-1:11] are all copies of bit 11,
    // i.e. the value is a sign extension of its low 12 bits.
    function automatic logic mem_offset_ok(input logic [REG_LEN-1:0] v);
        return (&v[REG_LEN-1:OPND_W-1]) | ~(|v[REG_LEN-1:OPND_W-1]);
    endfunction

endpackage

// File: rtl/rotl_even.sv
// Combinational rotate-left of a register-width word by 2*rot bit positions.
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
// Ports: din (word to rotate), rot (4-bit half-rotation amount), dout (result).
module rotl_even
    import imm_rot_encoder_pkg::*;
(
    input  logic [REG_LEN-1:0] din,
    input  logic [ROT_W-1:0]   rot,
    output logic [REG_LEN-1:0] dout
);

    logic [2*REG_LEN-1:0] dbl;

    // Shifting a doubled copy left and keeping the upper half is a rotate-left.
    always_comb begin
        dbl  = {din, din} << {rot, 1'b0};
        dout = dbl[2*REG_LEN-1:REG_LEN];
    end

endmodule

// File: rtl/imm_rot_encoder.sv
// Encodes a constant as a rotated 8-bit immediate or as a 12-bit signed memory offset.
// Latency: mem mode 1 cycle; immediate mode rot+1 cycles (16 on miss; 17+k / 32 with IMM_ENC_NEG_EN).
// Backpressure: in_ready only in IDLE; result held in DONE until out_valid && out_ready.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   in_valid/in_ready  request handshake; value and is_mem_command captured on it
//   out_valid/out_ready result handshake
//   shift_operand      {rot, imm8} (immediate) or value[11:0] (memory)
//   fail               value not encodable in the selected mode
//   inverted           result encodes ~value (only when IMM_ENC_NEG_EN is defined)
// Optional feature macro: IMM_ENC_NEG_EN (second search pass over ~value).
module imm_rot_encoder
    import imm_rot_encoder_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [`REGISTER_LEN-1:0] value,
    input  logic                     is_mem_command,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPND_W-1:0]        shift_operand,
    output logic                     fail,
    output logic                     inverted
);

    state_e              state_q, state_d;
    logic [REG_LEN-1:0]  operand_q, operand_d;
    logic                mem_q, mem_d;
    logic [ROT_W-1:0]    rot_q, rot_d;
    logic [OPND_W-1:0]   shift_operand_q, shift_operand_d;
    logic                fail_q, fail_d;
`ifdef IMM_ENC_NEG_EN
    logic                inverted_q, inverted_d;
`endif

    logic [REG_LEN-1:0]  candidate;
    logic                hit;

    rotl_even u_rotl_even (
        .din  (operand_q),
        .rot  (rot_q),
        .dout (candidate)
    );

    // Candidate fits in 8 bits: everything above imm8 is zero.
    assign hit = ~(|candidate[REG_LEN-1:8]);

    always_comb begin
        state_d         = state_q;
        operand_d       = operand_q;
        mem_d           = mem_q;
        rot_d           = rot_q;
        shift_operand_d = shift_operand_q;
        fail_d          = fail_q;
`ifdef IMM_ENC_NEG_EN
        inverted_d      = inverted_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    operand_d = value;
                    mem_d     = is_mem_command;
                    rot_d     = '0;
                    state_d   = ST_SEARCH;
                end
            end

            ST_SEARCH: begin
`ifdef IMM_ENC_NEG_EN
                inverted_d = 1'b0;
`endif
                if (mem_q) begin
                    // Memory mode resolves in a single evaluation cycle.
                    if (mem_offset_ok(operand_q)) begin
                        shift_operand_d = operand_q[OPND_W-1:0];
                        fail_d          = 1'b0;
                    end else begin
                        shift_operand_d = '0;
                        fail_d          = 1'b1;
                    end
                    state_d = ST_DONE;
                end else if (hit) begin
                    shift_operand_d = {rot_q, candidate[7:0]};
                    fail_d          = 1'b0;
                    rot_d           = '0;
                    state_d         = ST_DONE;
                end else if (rot_q == ROT_LAST) begin
`ifdef IMM_ENC_NEG_EN
                    // Retry with the complement so MVN/BIC forms can be used.
                    operand_d = ~operand_q;
                    rot_d     = '0;
                    state_d   = ST_SEARCH_NEG;
`else
                    shift_operand_d = '0;
                    fail_d          = 1'b1;
                    rot_d           = '0;
                    state_d         = ST_DONE;
`endif
                end else begin
                    rot_d = rot_q + 1'b1;
                end
            end

`ifdef IMM_ENC_NEG_EN
            ST_SEARCH_NEG: begin
                if (hit) begin
                    shift_operand_d = {rot_q, candidate[7:0]};
                    fail_d          = 1'b0;
                    inverted_d      = 1'b1;
                    rot_d           = '0;
                    state_d         = ST_DONE;
                end else if (rot_q == ROT_LAST) begin
                    shift_operand_d = '0;
                    fail_d          = 1'b1;
                    inverted_d      = 1'b0;
                    rot_d           = '0;
                    state_d         = ST_DONE;
                end else begin
                    rot_d = rot_q + 1'b1;
                end
            end
`endif

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            operand_q       <= '0;
            mem_q           <= 1'b0;
            rot_q           <= '0;
            shift_operand_q <= '0;
            fail_q          <= 1'b0;
`ifdef IMM_ENC_NEG_EN
            inverted_q      <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            operand_q       <= operand_d;
            mem_q           <= mem_d;
            rot_q           <= rot_d;
            shift_operand_q <= shift_operand_d;
            fail_q          <= fail_d;
`ifdef IMM_ENC_NEG_EN
            inverted_q      <= inverted_d;
`endif
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign out_valid     = (state_q == ST_DONE);
    assign shift_operand = shift_operand_q;
    assign fail          = fail_q;
`ifdef IMM_ENC_NEG_EN
    assign inverted      = inverted_q;
`else
    assign inverted      = 1'b0;
`endif

endmodule
